// File: rtl/uc_bus_pkg.sv
// Shared definitions for the microcontroller-side bus initiator: widths,
// command opcodes and the sequencer state encoding.
package uc_bus_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 8;

   localparam logic [1:0] OP_SET_ADDR = 2'd0;
   localparam logic [1:0] OP_WRITE    = 2'd1;
   localparam logic [1:0] OP_READ     = 2'd2;

   typedef enum logic [3:0] {
      IDLE,
      A_SETUP,
      A_STROBE,
      A_LOW,
      W_SETUP,
      W_ACK,
      W_NACK,
      R_TURN,
      R_ACK,
      R_NACK,
      I_STROBE,
      I_LOW,
      RESP
   } state_t;

endpackage

// File: rtl/uc_ack_sync.sv
// Two-flop synchroniser for CPLD status inputs that are asynchronous to clk.
// Both stages clear to 0 on reset.
module uc_ack_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= d[gi];
               sync_reg <= meta_reg;
            end
         end

         assign q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/uc_bus_master.sv
// Initiator for the cartridge CPLD's microcontroller port: turns SET_ADDR /
// WRITE / READ commands into strobe and four-phase ack sequences.
module uc_bus_master
   import uc_bus_pkg::*;
#(
   parameter int SETUP_CYCLES   = 2,
   parameter int STROBE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_inc,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [DATA_W-1:0] uc_data_o,
   output logic              uc_data_oe,
   input  logic [DATA_W-1:0] uc_data_i,
   output logic              uc_write,
   output logic              uc_read,
   input  logic              uc_ack,
   output logic              set_addr_lo,
   output logic              set_addr_hi,
   output logic              strobe_addr
);

   localparam int PH_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int CNT_W  = $clog2(PH_MAX + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t                  state_reg;
   logic [1:0]              op_reg;
   logic [ADDR_W-9:0]       addr_hi_reg;
   logic                    inc_reg;
   logic                    hi_byte_reg;
   logic [DATA_W-1:0]       rd_data_reg;
   logic [CNT_W-1:0]        cnt_reg;
   logic [TMO_W-1:0]        tmo_reg;
   logic                    ack_s;
   logic                    waiting;
   logic                    tmo_hit;
   logic [DATA_W-1:0]       resp_byte;

   uc_ack_sync #(
      .WIDTH (1)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (uc_ack),
      .q   (ack_s)
   );

   assign waiting   = (state_reg == W_ACK) || (state_reg == W_NACK) ||
                      (state_reg == R_ACK) || (state_reg == R_NACK);
   assign tmo_hit   = waiting && (tmo_reg == TMO_LAST);
   assign resp_byte = (op_reg == OP_READ) ? rd_data_reg : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         op_reg      <= '0;
         addr_hi_reg <= '0;
         inc_reg     <= 1'b0;
         hi_byte_reg <= 1'b0;
         rd_data_reg <= '0;
         cnt_reg     <= '0;
         tmo_reg     <= '0;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_err     <= 1'b0;
         uc_data_o   <= '0;
         uc_data_oe  <= 1'b0;
         uc_write    <= 1'b0;
         uc_read     <= 1'b0;
         set_addr_lo <= 1'b0;
         set_addr_hi <= 1'b0;
         strobe_addr <= 1'b0;
      end else begin
         // Response fields live for exactly the one RESP pulse cycle.
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         cnt_reg   <= cnt_reg + 1'b1;
         tmo_reg   <= tmo_reg + 1'b1;

         if (tmo_hit) begin
            uc_write   <= 1'b0;
            uc_read    <= 1'b0;
            uc_data_oe <= 1'b0;
            uc_data_o  <= '0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            state_reg  <= RESP;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (cmd_valid && cmd_ready) begin
                     cmd_ready   <= 1'b0;
                     op_reg      <= cmd_op;
                     addr_hi_reg <= cmd_addr[ADDR_W-1:8];
                     inc_reg     <= cmd_inc;
                     hi_byte_reg <= 1'b0;
                     cnt_reg     <= '0;
                     case (cmd_op)
                        OP_SET_ADDR: begin
                           uc_data_oe  <= 1'b1;
                           uc_data_o   <= cmd_addr[7:0];
                           set_addr_lo <= 1'b1;
                           state_reg   <= A_SETUP;
                        end
                        OP_WRITE: begin
                           uc_data_oe <= 1'b1;
                           uc_data_o  <= cmd_data;
                           state_reg  <= W_SETUP;
                        end
                        OP_READ: begin
                           uc_data_oe <= 1'b0;
                           state_reg  <= R_TURN;
                        end
                        default: state_reg <= RESP;
                     endcase
                  end
               end
               A_SETUP: begin
                  if (cnt_reg == SETUP_LAST) begin
                     strobe_addr <= 1'b1;
                     cnt_reg     <= '0;
                     state_reg   <= A_STROBE;
                  end
               end
               A_STROBE: begin
                  if (cnt_reg == STROBE_LAST) begin
                     strobe_addr <= 1'b0;
                     cnt_reg     <= '0;
                     state_reg   <= A_LOW;
                  end
               end
               A_LOW: begin
                  if (cnt_reg == STROBE_LAST) begin
                     cnt_reg <= '0;
                     if (!hi_byte_reg) begin
                        // Selects swap in one edge, so they are never high together.
                        hi_byte_reg <= 1'b1;
                        set_addr_lo <= 1'b0;
                        set_addr_hi <= 1'b1;
                        uc_data_o   <= {1'b0, addr_hi_reg};
                        state_reg   <= A_SETUP;
                     end else begin
                        set_addr_hi <= 1'b0;
                        uc_data_oe  <= 1'b0;
                        uc_data_o   <= '0;
                        rsp_valid   <= 1'b1;
                        state_reg   <= RESP;
                     end
                  end
               end
               W_SETUP: begin
                  if (cnt_reg == SETUP_LAST) begin
                     uc_write  <= !ack_s;
                     tmo_reg   <= '0;
                     state_reg <= W_ACK;
                  end
               end
               W_ACK: begin
                  if (uc_write && ack_s) begin
                     uc_write  <= 1'b0;
                     tmo_reg   <= '0;
                     state_reg <= W_NACK;
                  end else if (!uc_write && !ack_s) begin
                     uc_write <= 1'b1;
                  end
               end
               R_TURN: begin
                  uc_read   <= !ack_s;
                  tmo_reg   <= '0;
                  state_reg <= R_ACK;
               end
               R_ACK: begin
                  if (uc_read && ack_s) begin
                     // CPLD has its byte on the bus before it raises ack.
                     rd_data_reg <= uc_data_i;
                     uc_read     <= 1'b0;
                     tmo_reg     <= '0;
                     state_reg   <= R_NACK;
                  end else if (!uc_read && !ack_s) begin
                     uc_read <= 1'b1;
                  end
               end
               W_NACK, R_NACK: begin
                  if (!ack_s) begin
                     uc_data_oe <= 1'b0;
                     uc_data_o  <= '0;
                     cnt_reg    <= '0;
                     if (inc_reg) begin
                        strobe_addr <= 1'b1;
                        state_reg   <= I_STROBE;
                     end else begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= resp_byte;
                        state_reg <= RESP;
                     end
                  end
               end
               I_STROBE: begin
                  if (cnt_reg == STROBE_LAST) begin
                     strobe_addr <= 1'b0;
                     cnt_reg     <= '0;
                     state_reg   <= I_LOW;
                  end
               end
               I_LOW: begin
                  if (cnt_reg == STROBE_LAST) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= resp_byte;
                     state_reg <= RESP;
                  end
               end
               RESP: begin
                  // A reserved op arrives here without a pending pulse and
                  // spends one cycle producing its error response.
                  if (rsp_valid) begin
                     cmd_ready <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uc_bus_master.sv
// Directed bench for uc_bus_master against a behavioural CPLD (pointer, RAM,
// four-phase ack) with bus-protocol monitors.
module tb_uc_bus_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [14:0] cmd_addr;
   logic [7:0]  cmd_data;
   logic        cmd_inc;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic [7:0]  uc_data_o;
   logic        uc_data_oe;
   logic        uc_write;
   logic        uc_read;
   logic        set_addr_lo;
   logic        set_addr_hi;
   logic        strobe_addr;

   // CPLD model state
   logic [7:0]  m_ram [0:32767];
   logic [14:0] m_ptr = '0;
   logic        m_ack = 1'b0;
   logic [7:0]  m_rd = '0;
   logic        m_prev_strobe = 1'b0;
   logic        m_prev_write = 1'b0;
   logic        m_prev_read = 1'b0;
   logic        m_prev_oe = 1'b0;
   logic [13:0] prev_bus = '0;
   logic [7:0]  lo_loaded = '0;
   logic [7:0]  hi_loaded = '0;
   logic        no_ack = 1'b0;
   logic        in_write = 1'b0;
   logic [7:0]  wr_exp = '0;

   int strobe_rises = 0;
   int both_sel_err = 0;
   int wr_rise_err  = 0;
   int wr_data_err  = 0;
   int wr_high      = 0;
   int overlap_err  = 0;
   int rd_rise_err  = 0;
   int rsp_pulses   = 0;
   int toggles      = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uc_bus_master #(
      .SETUP_CYCLES   (2),
      .STROBE_CYCLES  (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .cmd_inc     (cmd_inc),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .uc_data_o   (uc_data_o),
      .uc_data_oe  (uc_data_oe),
      .uc_data_i   (m_rd),
      .uc_write    (uc_write),
      .uc_read     (uc_read),
      .uc_ack      (m_ack),
      .set_addr_lo (set_addr_lo),
      .set_addr_hi (set_addr_hi),
      .strobe_addr (strobe_addr)
   );

   // Behavioural CPLD plus protocol monitors, evaluated away from the active edge.
   always @(negedge clk) begin
      if (strobe_addr && !m_prev_strobe) begin
         strobe_rises <= strobe_rises + 1;
         if (set_addr_lo && set_addr_hi) begin
            both_sel_err <= both_sel_err + 1;
         end else if (set_addr_lo) begin
            m_ptr[7:0] <= uc_data_o;
            lo_loaded  <= uc_data_o;
         end else if (set_addr_hi) begin
            m_ptr[14:8] <= uc_data_o[6:0];
            hi_loaded   <= uc_data_o;
         end else begin
            m_ptr <= m_ptr + 15'd1;
         end
      end
      if (!uc_write && !uc_read) begin
         m_ack <= 1'b0;
      end else if (!m_ack && !no_ack) begin
         m_ack <= 1'b1;
         if (uc_write) m_ram[m_ptr] <= uc_data_o;
         else          m_rd <= m_ram[m_ptr];
      end
      if (uc_write && !m_prev_write && m_ack) wr_rise_err <= wr_rise_err + 1;
      if (uc_write && !uc_data_oe) wr_data_err <= wr_data_err + 1;
      if (in_write && uc_data_oe && uc_data_o !== wr_exp) wr_data_err <= wr_data_err + 1;
      if (uc_write) wr_high <= wr_high + 1;
      if (uc_read && uc_data_oe) overlap_err <= overlap_err + 1;
      if (uc_read && !m_prev_read && m_prev_oe) rd_rise_err <= rd_rise_err + 1;
      if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
      if ({uc_data_oe, uc_data_o, uc_write, uc_read, set_addr_lo, set_addr_hi, strobe_addr} !== prev_bus)
         toggles <= toggles + 1;
      prev_bus      <= {uc_data_oe, uc_data_o, uc_write, uc_read, set_addr_lo, set_addr_hi, strobe_addr};
      m_prev_strobe <= strobe_addr;
      m_prev_write  <= uc_write;
      m_prev_read   <= uc_read;
      m_prev_oe     <= uc_data_oe;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one command; lat counts falling edges from acceptance to rsp_valid.
   task automatic do_cmd(input logic [1:0] op, input logic [14:0] addr, input logic [7:0] data,
                         input logic inc, output int lat, output logic [7:0] rdata, output logic err);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      in_write  = (op == 2'd1);
      wr_exp    = data;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cmd_inc   = inc;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      rdata = rsp_data;
      err   = rsp_err;
      $display("TXN op=%0d addr=0x%04h data=0x%02h inc=%0d lat=%0d rsp_data=0x%02h rsp_err=%0d",
               op, addr, data, inc, lat, rdata, err);
      @(negedge clk);
      in_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         snap_a;
      int         snap_b;
      int         n;
      logic [7:0] rd;
      logic       er;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_addr  = '0;
      cmd_data  = '0;
      cmd_inc   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_bus_lines", {uc_write, uc_read, uc_data_oe, strobe_addr, set_addr_lo, set_addr_hi}, 0);
      check("rst_data_o", uc_data_o, 0);

      // SET_ADDR 0x5A3C
      snap_a = rsp_pulses;
      do_cmd(2'd0, 15'h5A3C, 8'h00, 1'b0, lat, rd, er);
      check("sa_latency", lat, 13);
      check("sa_err", er, 0);
      check("sa_lo_byte", lo_loaded, 8'h3C);
      check("sa_hi_byte", hi_loaded, 8'h5A);
      check("sa_pointer", m_ptr, 15'h5A3C);
      check("sa_rsp_count", rsp_pulses - snap_a, 1);
      check("sa_both_sel", both_sel_err, 0);

      // WRITE 0xA5 with increment at 0x0010
      do_cmd(2'd0, 15'h0010, 8'h00, 1'b0, lat, rd, er);
      check("wr_setaddr_ptr", m_ptr, 15'h0010);
      do_cmd(2'd1, 15'h0000, 8'hA5, 1'b1, lat, rd, er);
      check("wr_err", er, 0);
      check("wr_rsp_data", rd, 0);
      check("wr_ram", m_ram[15'h0010], 8'hA5);
      check("wr_pointer_inc", m_ptr, 15'h0011);
      check("wr_stale_rise", wr_rise_err, 0);
      check("wr_data_stable", wr_data_err, 0);

      // READ at 0x7FFF (seeded with 0x3C) with increment wraps the pointer
      do_cmd(2'd0, 15'h7FFF, 8'h00, 1'b0, lat, rd, er);
      check("rd_hi_byte", hi_loaded, 8'h7F);
      do_cmd(2'd1, 15'h0000, 8'h3C, 1'b0, lat, rd, er);
      check("rd_seed_ram", m_ram[15'h7FFF], 8'h3C);
      do_cmd(2'd2, 15'h0000, 8'h00, 1'b1, lat, rd, er);
      check("rd_data", rd, 8'h3C);
      check("rd_err", er, 0);
      check("rd_pointer_wrap", m_ptr, 15'h0000);
      check("rd_oe_overlap", overlap_err, 0);
      check("rd_turnaround", rd_rise_err, 0);

      // WRITE that is never acknowledged times out after 16 cycles
      no_ack = 1'b1;
      snap_a = wr_high;
      snap_b = strobe_rises;
      do_cmd(2'd1, 15'h0000, 8'h11, 1'b1, lat, rd, er);
      no_ack = 1'b0;
      check("to_err", er, 1);
      check("to_rsp_data", rd, 0);
      check("to_latency", lat, 19);
      check("to_write_cycles", wr_high - snap_a, 16);
      check("to_no_inc_strobe", strobe_rises - snap_b, 0);
      check("to_pointer", m_ptr, 15'h0000);
      check("to_lines_low", {uc_write, uc_data_oe}, 0);
      do_cmd(2'd0, 15'h0123, 8'h00, 1'b0, lat, rd, er);
      check("to_next_latency", lat, 13);
      check("to_next_err", er, 0);
      check("to_next_ptr", m_ptr, 15'h0123);
      do_cmd(2'd1, 15'h0000, 8'h77, 1'b0, lat, rd, er);
      check("to_write_after", m_ram[15'h0123], 8'h77);

      // Reset while waiting for ack in a READ
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      cmd_inc   = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!uc_read && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rr_reach_read", uc_read, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rr_uc_read", uc_read, 0);
      check("rr_uc_data_oe", uc_data_oe, 0);
      check("rr_cmd_ready", cmd_ready, 1);
      check("rr_rsp_valid", rsp_valid, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      do_cmd(2'd2, 15'h0000, 8'h00, 1'b0, lat, rd, er);
      check("rr_read_data", rd, 8'h77);
      check("rr_read_err", er, 0);
      check("rr_pointer", m_ptr, 15'h0123);

      // Reserved opcode: error response, no bus activity
      snap_a = toggles;
      do_cmd(2'd3, 15'h7FFF, 8'hFF, 1'b1, lat, rd, er);
      check("op3_latency", lat, 2);
      check("op3_err", er, 1);
      check("op3_rsp_data", rd, 0);
      check("op3_no_toggle", toggles - snap_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uc_bus_master.md
Name: uc_bus_master

Overview:
- Clocked initiator for the cartridge CPLD's microcontroller-side parallel port; it plays the role the microcontroller plays today.
- Accepts simple commands from a host-side client:
  - SET_ADDR: load the 15-bit RAM address pointer.
  - WRITE: write one byte.
  - READ: read one byte.
- Drives set_addr_lo / set_addr_hi / strobe_addr / uc_write / uc_read and the shared uc_data bus.
- Completes each access with the four-phase uc_ack handshake, optionally pulses the pointer post-increment, then returns one response per command.

Parameters:
SETUP_CYCLES, 2, clk cycles uc_data/select lines are stable before a strobe_addr rising edge or before uc_write assertion
STROBE_CYCLES, 2, clk cycles strobe_addr is held high; also the minimum low time after it
TIMEOUT_CYCLES, 1024, max clk cycles to wait for each uc_ack edge before aborting; width = $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  2  0=SET_ADDR, 1=WRITE, 2=READ, 3=reserved (answered with error, no bus activity)
cmd_addr  input  15  address for SET_ADDR
cmd_data  input  8  byte for WRITE
cmd_inc  input  1  after WRITE/READ, pulse strobe_addr with no select line (pointer +1)
rsp_valid  output  1  one-cycle response pulse
rsp_data  output  8  byte read (READ); 0 otherwise
rsp_err  output  1  timeout or reserved op
uc_data_o  output  8  bus drive value
uc_data_oe  output  1  bus drive enable
uc_data_i  input  8  bus sampled value
uc_write  output  1  write request to CPLD
uc_read  output  1  read request to CPLD
uc_ack  input  1  CPLD acknowledge, asynchronous to clk
set_addr_lo  output  1  strobe selects low address byte
set_addr_hi  output  1  strobe selects high address bits
strobe_addr  output  1  address strobe; CPLD acts on rising edge

Behaviour:
- Reset values:
  - All outputs 0, except cmd_ready=1.
  - State IDLE; counters cleared; synchroniser flops 0.
  - Reset mid-operation releases every line within that cycle. The CPLD's ack clears itself once both requests are low.
- uc_ack passes through a 2-flop synchroniser; all decisions use the synchronised value (ack_s).
- Command acceptance:
  - Accept on cmd_valid & cmd_ready; command fields are latched.
  - cmd_ready is low from the cycle after acceptance until the cycle after rsp_valid.
- States: IDLE, A_SETUP, A_STROBE, A_LOW, W_SETUP, W_ACK, W_NACK, R_TURN, R_ACK, R_NACK, I_STROBE, I_LOW, RESP.
- SET_ADDR, executed twice: low byte, then high byte.
  - A_SETUP (SETUP_CYCLES): uc_data_oe=1, uc_data_o = addr[7:0] with set_addr_lo=1, or {1'b0, addr[14:8]} with set_addr_hi=1.
  - A_STROBE (STROBE_CYCLES): strobe_addr=1.
  - A_LOW (STROBE_CYCLES): strobe low, select and data held.
  - After the high byte, drop the select line and go to RESP.
  - set_addr_lo and set_addr_hi are never high together.
- WRITE:
  - W_SETUP: drive cmd_data for SETUP_CYCLES.
  - W_ACK: uc_write=1 until ack_s=1.
  - W_NACK: uc_write=0, data still driven, until ack_s=0.
  - Then go to I_STROBE if cmd_inc, else RESP.
- READ:
  - R_TURN: uc_data_oe=0 for one cycle before uc_read rises (bus turnaround). uc_data_oe and uc_read are never high together.
  - R_ACK: uc_read=1 until ack_s=1. uc_data_i is sampled into rsp_data in the cycle ack_s is first seen high; the CPLD latched its data before raising ack.
  - R_NACK: uc_read=0 until ack_s=0.
- Increment:
  - I_STROBE: strobe_addr=1 for STROBE_CYCLES with both selects 0.
  - I_LOW: low for STROBE_CYCLES.
  - Then RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Timeout:
  - The counter restarts on entry to W_ACK, W_NACK, R_ACK and R_NACK.
  - Reaching TIMEOUT_CYCLES deasserts uc_write, uc_read and uc_data_oe, skips the increment, and goes to RESP with rsp_err=1 and rsp_data=0.
- ack_s already high on entry to W_ACK/R_ACK (stale ack): wait in the *_NACK-like precondition first. Request lines are asserted only after ack_s=0 has been seen; this check is included in the timeout.
- Latency with zero-delay ack, ignoring the synchroniser:
  - SET_ADDR: 2*(SETUP+2*STROBE)+1 cycles.
  - WRITE without increment: SETUP + 2 ack waits of ≥3 cycles each + 1.

Decomposition:
- Shared package uc_bus_pkg:
  - op encodings (OP_SET_ADDR, OP_WRITE, OP_READ).
  - state enum.
  - ADDR_W=15, DATA_W=8.
- One sub-module, uc_ack_sync: 2-flop synchroniser with reset to 0, reusable for the other CPLD status inputs.

Test Plan:
- SET_ADDR 0x5A3C with a behavioural CPLD model:
  - Required response: lo strobe loads 0x3C, hi strobe loads 0x5A.
  - The model's pointer equals 0x5A3C.
  - One rsp_valid with rsp_err=0.
  - No strobe while both selects are set.
- WRITE 0xA5 with cmd_inc=1 at pointer 0x0010:
  - Required response: model RAM[0x0010]=0xA5, pointer=0x0011.
  - uc_write is high only while the model ack is low→high.
  - Data is stable from W_SETUP through W_NACK.
- READ with RAM[0x7FFF]=0x3C and cmd_inc=1:
  - Required response: rsp_data=0x3C, pointer wraps to 0x0000.
  - uc_data_oe is 0 for ≥1 cycle before uc_read rises and never overlaps it.
- Model never acks a WRITE, TIMEOUT_CYCLES=16:
  - Required response: uc_write drops after 16 cycles, rsp_err=1.
  - No increment strobe; next command is accepted normally.
- Assert rst during R_ACK:
  - Required response: next cycle uc_read=0, uc_data_oe=0, cmd_ready=1, rsp_valid=0.
  - Subsequent READ succeeds after the model clears ack.
- cmd_op=3:
  - Required response: no bus line toggles, rsp_valid with rsp_err=1 a fixed 2 cycles after accept.
